// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode latch outputs,
// and the downstream control inputs (load, stall, redirect).
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic        ld_de;
  logic        br_stall;
  logic        redirect_v;
  logic [63:0] redirect_pc;
  logic [63:0] de_npc;
  logic [31:0] de_ir;
  logic        de_v;

  modport master (
    output imem_req, imem_addr, de_npc, de_ir, de_v,
    input  imem_rdy, imem_data, ld_de, br_stall, redirect_v, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, de_npc, de_ir, de_v,
    output imem_rdy, imem_data, ld_de, br_stall, redirect_v, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV64 fetch stage: owns the PC, keeps one imem request outstanding, buffers one
// instruction against decode back-pressure and flushes wrong-path work on redirect.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] faddr_q, faddr_d;
  logic        fb_v_q, fb_v_d;
  logic [31:0] fb_ir_q, fb_ir_d;
  logic [63:0] fb_npc_q, fb_npc_d;
  logic        de_v_q, de_v_d;
  logic [31:0] de_ir_q, de_ir_d;
  logic [63:0] de_npc_q, de_npc_d;

  logic        resp_v;
  logic [63:0] resp_npc;
  logic [63:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~64'h3;
  assign resp_npc     = faddr_q + 64'd4;
  // A response is only useful in WAIT; in DROP, or with a redirect, it is wrong-path.
  assign resp_v       = (state_q == S_WAIT) && bus.imem_rdy && !bus.redirect_v;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    faddr_d  = faddr_q;
    fb_v_d   = fb_v_q;
    fb_ir_d  = fb_ir_q;
    fb_npc_d = fb_npc_q;
    de_v_d   = de_v_q;
    de_ir_d  = de_ir_q;
    de_npc_d = de_npc_q;

    if (bus.redirect_v) begin
      pc_d = redirect_tgt;
      // An in-flight request cannot be withdrawn, so drain it in DROP.
      if (state_q != S_IDLE) begin
        state_d = bus.imem_rdy ? S_IDLE : S_DROP;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.br_stall && !fb_v_q) begin
            faddr_d = pc_q;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rdy) begin
            pc_d    = resp_npc;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.imem_rdy) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (bus.redirect_v) begin
      de_v_d = 1'b0;
      fb_v_d = 1'b0;
    end else if (bus.ld_de) begin
      if (fb_v_q) begin
        de_v_d   = 1'b1;
        de_ir_d  = fb_ir_q;
        de_npc_d = fb_npc_q;
        fb_v_d   = 1'b0;
      end else if (resp_v) begin
        de_v_d   = 1'b1;
        de_ir_d  = bus.imem_data;
        de_npc_d = resp_npc;
      end else begin
        de_v_d = 1'b0;
      end
    end else if (resp_v) begin
      // Issue requires an empty buffer, so this fill never overwrites a valid entry.
      fb_v_d   = 1'b1;
      fb_ir_d  = bus.imem_data;
      fb_npc_d = resp_npc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      faddr_q  <= 64'h0;
      fb_v_q   <= 1'b0;
      fb_ir_q  <= 32'h0;
      fb_npc_q <= 64'h0;
      de_v_q   <= 1'b0;
      de_ir_q  <= 32'h0;
      de_npc_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      faddr_q  <= faddr_d;
      fb_v_q   <= fb_v_d;
      fb_ir_q  <= fb_ir_d;
      fb_npc_q <= fb_npc_d;
      de_v_q   <= de_v_d;
      de_ir_q  <= de_ir_d;
      de_npc_q <= de_npc_d;
    end
  end

  assign bus.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign bus.imem_addr = faddr_q;
  assign bus.de_v      = de_v_q;
  assign bus.de_ir     = de_ir_q;
  assign bus.de_npc    = de_npc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model answers
// requests, and every instruction decode accepts is matched against a scoreboard.
module tb_fetch_stage;
  localparam logic [63:0] RST_PC = 64'h1000;

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] npc;
  } de_t;

  logic clk;
  logic reset;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  mem_lat = 1;
  int  mem_cnt = 0;
  de_t exp_q[$];

  function automatic logic [31:0] fn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_de(input logic [63:0] addr);
    de_t e;
    e.ir  = fn(addr);
    e.npc = addr + 64'd4;
    exp_q.push_back(e);
  endtask

  // One clock: scoreboard any instruction decode took at this edge, then let the
  // memory model drive ready/data for the coming cycle.
  task automatic tick();
    logic ld_p, rd_p, rs_p;
    de_t  e;
    ld_p = bus.ld_de;
    rd_p = bus.redirect_v;
    rs_p = reset;
    @(posedge clk);
    #1;
    if (!rs_p && ld_p && !rd_p && bus.de_v === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL de_unexpected: observed npc=%h ir=%h expected no delivery", bus.de_npc, bus.de_ir);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("de_ir", {32'h0, bus.de_ir}, {32'h0, e.ir});
        chk("de_npc", bus.de_npc, e.npc);
        $display("DE accepted npc=%h ir=%h", bus.de_npc, bus.de_ir);
      end
    end
    if (bus.imem_req) begin
      mem_cnt++;
      bus.imem_rdy  = (mem_cnt >= mem_lat);
      bus.imem_data = fn(bus.imem_addr);
    end else begin
      mem_cnt       = 0;
      bus.imem_rdy  = 1'b0;
      bus.imem_data = 32'h0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {63'h0, bus.imem_req}, 64'h0);
    chk({tag, "_addr"},  bus.imem_addr, 64'h0);
    chk({tag, "_dev"},   {63'h0, bus.de_v}, 64'h0);
    chk({tag, "_deir"},  {32'h0, bus.de_ir}, 64'h0);
    chk({tag, "_denpc"}, bus.de_npc, 64'h0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.ld_de       = 1'b1;
    bus.br_stall    = 1'b0;
    bus.redirect_v  = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.imem_rdy    = 1'b0;
    bus.imem_data   = 32'h0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Streaming with a 1-cycle memory: one instruction every two cycles.
    for (int i = 0; i < 3; i++) begin
      expect_de(RST_PC + 64'(4 * i));
      tick();
      chk("t1_req", {63'h0, bus.imem_req}, 64'h1);
      chk("t1_addr", bus.imem_addr, RST_PC + 64'(4 * i));
      chk("t1_dev_gap", {63'h0, bus.de_v}, 64'h0);
      tick();
      chk("t1_dev", {63'h0, bus.de_v}, 64'h1);
    end

    // Decode back-pressure: one more fetch lands in the buffer, then issue stops.
    bus.ld_de = 1'b0;
    expect_de(64'h100C);
    tick();
    chk("t2_addr", bus.imem_addr, 64'h100C);
    tick();
    chk("t2_hold_v", {63'h0, bus.de_v}, 64'h1);
    chk("t2_hold_npc", bus.de_npc, 64'h100C);
    tick();
    chk("t2_noreq_a", {63'h0, bus.imem_req}, 64'h0);
    tick();
    chk("t2_noreq_b", {63'h0, bus.imem_req}, 64'h0);
    chk("t2_hold_npc2", bus.de_npc, 64'h100C);
    bus.ld_de = 1'b1;
    tick();
    chk("t2_fb_noreq", {63'h0, bus.imem_req}, 64'h0);
    expect_de(64'h1010);
    tick();
    chk("t2_resume_addr", bus.imem_addr, 64'h1010);
    chk("t2_resume_req", {63'h0, bus.imem_req}, 64'h1);
    tick();

    // Redirect while waiting; the late response must be dropped.
    mem_lat = 4;
    tick();
    chk("t3_addr", bus.imem_addr, 64'h1014);
    bus.redirect_v  = 1'b1;
    bus.redirect_pc = 64'h2003;
    tick();
    chk("t3_dev", {63'h0, bus.de_v}, 64'h0);
    chk("t3_drop_req", {63'h0, bus.imem_req}, 64'h1);
    bus.redirect_v = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_stale_dev", {63'h0, bus.de_v}, 64'h0);
    chk("t3_idle_req", {63'h0, bus.imem_req}, 64'h0);
    mem_lat = 1;
    expect_de(64'h2000);
    tick();
    chk("t3_tgt_addr", bus.imem_addr, 64'h2000);
    tick();

    // Redirect coinciding with the response.
    tick();
    chk("t4_addr", bus.imem_addr, 64'h2004);
    bus.redirect_v  = 1'b1;
    bus.redirect_pc = 64'h3000;
    tick();
    chk("t4_dev", {63'h0, bus.de_v}, 64'h0);
    chk("t4_req", {63'h0, bus.imem_req}, 64'h0);
    bus.redirect_v = 1'b0;
    expect_de(64'h3000);
    tick();
    chk("t4_tgt_addr", bus.imem_addr, 64'h3000);
    chk("t4_tgt_req", {63'h0, bus.imem_req}, 64'h1);
    tick();

    // Branch stall during WAIT: pending word still delivered, no new issue.
    mem_lat = 3;
    tick();
    chk("t5_addr", bus.imem_addr, 64'h3004);
    bus.br_stall = 1'b1;
    expect_de(64'h3004);
    tick();
    tick();
    tick();
    chk("t5_dev", {63'h0, bus.de_v}, 64'h1);
    tick();
    chk("t5_noreq_a", {63'h0, bus.imem_req}, 64'h0);
    tick();
    chk("t5_noreq_b", {63'h0, bus.imem_req}, 64'h0);
    bus.br_stall = 1'b0;
    mem_lat = 1;
    expect_de(64'h3008);
    tick();
    chk("t5_resume_addr", bus.imem_addr, 64'h3008);
    tick();

    // PC wraps modulo 2^64; redirect target low bits are cleared.
    bus.redirect_v  = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("wrap_redir_req", {63'h0, bus.imem_req}, 64'h0);
    bus.redirect_v = 1'b0;
    expect_de(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_addr_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    expect_de(64'h0);
    tick();
    chk("wrap_addr_zero", bus.imem_addr, 64'h0);
    tick();

    // Reset with a buffered instruction, then reset in the middle of a request.
    bus.ld_de = 1'b0;
    tick();
    tick();
    chk("t6_fb_noreq", {63'h0, bus.imem_req}, 64'h0);
    reset = 1'b1;
    tick();
    chk_reset_vals("t6_rst_fb");
    reset     = 1'b0;
    bus.ld_de = 1'b1;
    mem_lat   = 3;
    tick();
    chk("t6_restart_req", {63'h0, bus.imem_req}, 64'h1);
    chk("t6_restart_addr", bus.imem_addr, RST_PC);
    chk("t6_restart_dev", {63'h0, bus.de_v}, 64'h0);
    reset     = 1'b1;
    bus.ld_de = 1'b0;
    tick();
    chk_reset_vals("t6_rst_wait");
    reset     = 1'b0;
    bus.ld_de = 1'b1;
    mem_lat   = 1;
    expect_de(RST_PC);
    tick();
    chk("t6_final_addr", bus.imem_addr, RST_PC);
    tick();
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

RV64 instruction fetch stage, directly upstream of decode. Owns the PC, issues one-outstanding requests to the instruction memory, absorbs decode back-pressure with a one-entry fetch buffer, and drives the DE pipeline latch (DE_NPC, DE_IR, DE_V). Branch/jump/trap redirects from later stages flush wrong-path work, including a request already in flight.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high.
- IMEM_REQ  out  1  request outstanding; held high until IMEM_RDY.
- IMEM_ADDR  out  64  fetch address; stable while IMEM_REQ high.
- IMEM_RDY  in  1  response valid this cycle; ends current request.
- IMEM_DATA  in  32  instruction word, valid with IMEM_RDY.
- LD_DE  in  1  decode accepts; DE latch updates this edge.
- BR_STALL  in  1  unresolved control flow downstream; no new issue.
- REDIRECT_V  in  1  redirect PC and flush.
- REDIRECT_PC  in  64  redirect target; bits [1:0] forced to 0.
- DE_NPC  out  64  PC+4 of DE_IR.
- DE_IR  out  32  instruction to decode.
- DE_V  out  1  DE_IR/DE_NPC valid.

## Operation
- State: PC (64), FADDR (64, drives IMEM_ADDR), FB buffer {valid, ir, npc}, FSM {IDLE, WAIT, DROP}.
- IMEM_REQ = (state==WAIT or DROP).
- Issue condition: state IDLE, !BR_STALL, !REDIRECT_V, FB empty. On issue: FADDR<=PC, ->WAIT.
- WAIT + IMEM_RDY, no redirect: response {IMEM_DATA, FADDR+4}; PC<=FADDR+4; ->IDLE. Response goes to DE if LD_DE, else into FB.
- WAIT + REDIRECT_V, no IMEM_RDY: ->DROP (request cannot be withdrawn); PC<=target.
- WAIT or DROP + REDIRECT_V + IMEM_RDY: data discarded, PC<=target, ->IDLE.
- DROP + IMEM_RDY, no redirect: data discarded, ->IDLE; PC unchanged.
- DROP + REDIRECT_V, no IMEM_RDY: PC<=newest target, stay DROP.
- DE latch, when LD_DE: FB valid -> DE<=FB, FB cleared; else accepted response -> DE<=response; else DE_V<=0 (DE_IR/DE_NPC hold).
- LD_DE low: DE holds all fields.
- REDIRECT_V: DE_V<=0 and FB cleared at this edge regardless of LD_DE.
- FB fill and response cannot coincide with FB valid (issue requires FB empty); no overflow path.
- BR_STALL gates issue only; an outstanding request completes and delivers normally.
- PC arithmetic modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: IMEM_REQ=0, IMEM_ADDR=0, DE_V=0, DE_IR=0, DE_NPC=0, FB empty, state IDLE, PC=RESET_PC.
- RESET priority over all inputs; mid-request reset abandons request (imem shares RESET and drops it).
- First IMEM_REQ high in the cycle after the first non-reset edge.
- Request issued edge t -> earliest IMEM_RDY cycle t+1; DE_V high after that edge if LD_DE.
- Next issue edge after response edge at earliest; 1-cycle memory gives one instruction per 2 cycles.
- REDIRECT_V in cycle c: IMEM_REQ for target no earlier than cycle c+2 (IDLE) or after DROP completes.
- Priority: RESET > REDIRECT_V > IMEM_RDY > BR_STALL.

## Test plan
- Reset, RESET_PC=0x1000, 1-cycle memory, LD_DE=1 -> IMEM_ADDR 0x1000, 0x1004, 0x1008; DE_NPC 0x1004, 0x1008, 0x100C; DE_V high every other cycle.
- LD_DE low 4 cycles with DE valid -> one more fetch lands in FB, IMEM_REQ stays low; LD_DE high -> FB delivered next edge, then fetch resumes at next PC.
- REDIRECT_V to 0x2003 while WAIT, IMEM_RDY 3 cycles later -> stale word never reaches DE (DE_V=0), next IMEM_ADDR=0x2000.
- REDIRECT_V and IMEM_RDY same cycle -> DE_V=0, FB empty, next IMEM_ADDR=target.
- BR_STALL high 5 cycles during WAIT -> pending word delivered, no new IMEM_REQ until BR_STALL low.
- RESET asserted during WAIT with LD_DE=0, FB valid -> all outputs at reset values next edge; fetch restarts at RESET_PC.
